// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake and serial-side status for uart_tx_fifo.
// master = byte source (firmware glue), slave = the transmitter.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          ser_tx;
  logic          busy;
  logic [LW-1:0] fifo_level;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, ser_tx, busy, fifo_level
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, ser_tx, busy, fifo_level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) fed by a byte FIFO.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for CLK_DIV cycles
// DATA   | 8 data bits LSB first, CLK_DIV cycles each
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); chains straight into START if more bytes are queued
module uart_tx_fifo #(
  parameter int CLK_DIV    = 4167,
  parameter int FIFO_DEPTH = 8
) (
  input logic           clock,
  input logic           resetb,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_next;
  logic [2:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          baud_end, push, pop;
  logic          ser_tx_q, tx_ready_q, busy_q;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign push     = bus.tx_valid && tx_ready_q;
  assign pop      = (level != '0) && ((state == S_IDLE) || ((state == S_STOP) && baud_end));

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (pop && !push)
      level_next = level - LW'(1);
  end

  // Storage is not reset; the level and pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      ser_tx_q   <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        shift  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        parity <= ^mem[rd_ptr];
`endif
      end
      level      <= level_next;
      tx_ready_q <= (level_next != LVL_FULL);
      busy_q     <= (state != S_IDLE) || (level != '0);

      // The line follows the state one cycle later, so every bit still spans CLK_DIV cycles.
      case (state)
        S_START:  ser_tx_q <= 1'b0;
        S_DATA:   ser_tx_q <= shift[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: ser_tx_q <= parity;
`endif
        default:  ser_tx_q <= 1'b1;
      endcase

      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop)
            state <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= pop ? S_START : S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ser_tx     = ser_tx_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo; a software UART receiver decodes
// the line and is compared against the queue of accepted bytes.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic clock  = 1'b0;
  logic resetb = 1'b0;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic             prev_line = 1'b1;
  bit               rx_on     = 1'b0;
  int               rx_cnt    = 0;
  logic [NBITS-1:0] rx_bits;
  int               bad_frames = 0;
  logic [7:0]       got_q[$];
  logic [7:0]       exp_q[$];
  int               start_q[$];
  logic             par_q[$];
  int               k, t, lows, rise, g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  // One clock; sample #1 after the edge and run the receiver on the line.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (!resetb) begin
      rx_on = 1'b0;
    end else if (rx_on) begin
      rx_cnt++;
      if (rx_cnt % CLK_DIV == CLK_DIV / 2) begin
        rx_bits[rx_cnt / CLK_DIV] = bus.ser_tx;
        if (rx_cnt / CLK_DIV == NBITS - 1) begin
          rx_on = 1'b0;
          if (rx_bits[0] !== 1'b0 || rx_bits[NBITS-1] !== 1'b1) bad_frames++;
`ifdef UART_TX_PARITY_EN
          if (rx_bits[9] !== ^rx_bits[8:1]) bad_frames++;
          par_q.push_back(rx_bits[9]);
`endif
          got_q.push_back(rx_bits[8:1]);
        end
      end
    end else if (prev_line === 1'b1 && bus.ser_tx === 1'b0) begin
      rx_on  = 1'b1;
      rx_cnt = 0;
      start_q.push_back(cyc);
    end
    prev_line = bus.ser_tx;
  endtask

  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    int guard;
    guard = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && guard < 1000) begin
      step();
      guard++;
    end
    step();
    acc_cyc = cyc;
    bus.tx_valid = 1'b0;
    exp_q.push_back(b);
    if (guard >= 1000) check("push_timeout", 32'(guard), 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((bus.busy !== 1'b0 || bus.fifo_level !== '0 || rx_on) && guard < 5000) begin
      step();
      guard++;
    end
    check("drain_timeout", 32'(guard < 5000), 32'd1);
    repeat (4) step();
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_framing"}, 32'(bad_frames), 32'd0);
    got_q.delete();
    exp_q.delete();
    start_q.delete();
    par_q.delete();
    bad_frames = 0;
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // reset and release
    resetb = 1'b0;
    repeat (3) step();
    check("rst_ser_tx", 32'(bus.ser_tx), 32'd1);
    check("rst_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    resetb = 1'b1;
    step();
    check("rel_ready", 32'(bus.tx_ready), 32'd1);
    check("rel_busy", 32'(bus.busy), 32'd0);
    check("rel_ser_tx", 32'(bus.ser_tx), 32'd1);

    // single byte: exact line waveform and latency
    push_byte(8'hA5, k);
    check("a5_level", 32'(bus.fifo_level), 32'd1);
    step();
    check("a5_latency_idle", 32'(bus.ser_tx), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      check($sformatf("a5_line%0d", i), 32'(bus.ser_tx), 32'(frame_bit(8'hA5, i / CLK_DIV)));
    end
    check("a5_busy_in_stop", 32'(bus.busy), 32'd1);
    step();
    check("a5_busy_after", 32'(bus.busy), 32'd0);
    compare_rx("a5");

    // burst of 8 on consecutive cycles, then a 9th
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_ready%0d", i), 32'(bus.tx_ready), 32'd1);
      push_byte(8'(i), t);
    end
    check("burst_level7", 32'(bus.fifo_level), 32'd7);
    check("burst_ready9", 32'(bus.tx_ready), 32'd1);
    push_byte(8'h08, t);
    drain();
    check("burst_frames", 32'(start_q.size()), 32'd9);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(FRAME));
    compare_rx("burst");

    // FIFO full: one byte in flight plus DEPTH queued, then a held byte
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h10 + 8'(i), t);
      if (i == 0) k = t;
    end
    check("full_level", 32'(bus.fifo_level), 32'(DEPTH));
    check("full_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_data  = 8'h99;
    bus.tx_valid = 1'b1;
    g = 0;
    while (bus.tx_ready !== 1'b1 && g < 1000) begin
      step();
      g++;
    end
    rise = cyc;
    check("full_ready_rise", 32'(rise), 32'(k + 1 + FRAME));
    push_byte(8'h99, t);
    check("full_held_accept", 32'(t), 32'(rise + 1));
    check("full_level_after", 32'(bus.fifo_level), 32'(DEPTH));
    drain();
    compare_rx("full");

    // randomized bytes with random idle gaps
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) step();
      push_byte(8'($urandom_range(0, 255)), t);
      check("rand_level_max", 32'(bus.fifo_level <= DEPTH), 32'd1);
    end
    drain();
    compare_rx("rand");

    // reset during data bit 3 of 8'hFF with another byte queued
    push_byte(8'hFF, k);
    push_byte(8'h5A, t);
    exp_q.delete();
    repeat (18) step();
    check("mid_busy", 32'(bus.busy), 32'd1);
    check("mid_level", 32'(bus.fifo_level), 32'd1);
    resetb = 1'b0;
    step();
    check("mid_rst_ser_tx", 32'(bus.ser_tx), 32'd1);
    check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    resetb = 1'b1;
    lows = 0;
    repeat (200) begin
      step();
      if (bus.ser_tx !== 1'b1) lows++;
    end
    check("post_rst_line_idle", 32'(lows), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_level", 32'(bus.fifo_level), 32'd0);
    compare_rx("rst");

`ifdef UART_TX_PARITY_EN
    push_byte(8'h07, t);
    push_byte(8'h03, t);
    drain();
    check("par_frames", 32'(par_q.size()), 32'd2);
    if (par_q.size() == 2) begin
      check("par_07", 32'(par_q[0]), 32'd1);
      check("par_03", 32'(par_q[1]), 32'd0);
    end
    if (start_q.size() == 2)
      check("par_frame_len", 32'(start_q[1] - start_q[0]), 32'(11 * CLK_DIV));
    compare_rx("par");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
